// File: rtl/fetch_buffer.sv
// fetch_buffer
//
// Instruction-fetch back end sitting directly behind the program counter.
// Every address the PC issues to the instruction ROM is remembered for one
// cycle so it can be paired with the ROM word that comes back the following
// cycle. The {address, instruction} pairs are queued in a small FIFO and
// presented to the decode stage. The block holds the PC while the FIFO has
// no room for work already in flight. It also absorbs decode stalls and
// throws away all fetched-but-unconsumed work on a branch/exception flush.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   rom_en    in   PC is presenting a meaningful fetch address
//   pc_addr   in   current fetch address (also driven to the ROM)
//   rom_data  in   ROM read data for the address presented last cycle
//   flush     in   redirect: discard everything fetched but not consumed
//   stall_id  in   decode cannot accept an instruction this cycle
//   stall_pc  out  hold the PC (no room for another fetch)
//   id_valid  out  id_pc/id_inst carry a real instruction
//   id_pc     out  address of the presented instruction (0 when empty)
//   id_inst   out  presented instruction word (0 / NOP when empty)

module fetch_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_en,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  flush,
    input  logic                  stall_id,
    output logic                  stall_pc,
    output logic                  id_valid,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_inst
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [PTR_W-1:0]      r_wrPtr;
    logic                  r_reqValid;
    logic [ADDR_WIDTH-1:0] r_reqPc;

    logic [ADDR_WIDTH-1:0] r_memPc   [DEPTH];
    logic [DATA_WIDTH-1:0] r_memInst [DEPTH];

    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic [OCC_W-1:0]      w_occupancy;

    // Occupancy counts the queued entries plus the fetch whose ROM word is
    // still on its way. Stalling the PC on that sum is what makes a push
    // into a full FIFO impossible. The sum uses registers only, so stall_pc
    // has no combinational path from stall_id or flush.
    always_comb begin
        w_occupancy = OCC_W'(r_count) + OCC_W'(r_reqValid);
        stall_pc    = (w_occupancy >= OCC_W'(DEPTH));
        id_valid    = (r_count != '0);
        w_issue     = rom_en & ~stall_pc & ~flush;
        w_push      = r_reqValid & ~flush;
        w_pop       = id_valid & ~stall_id & ~flush;
        id_pc       = '0;
        id_inst     = '0;
        if (id_valid) begin
            id_pc   = r_memPc[r_rdPtr];
            id_inst = r_memInst[r_rdPtr];
        end
    end

    // Request tracking, FIFO pointers and count. Flush has priority over
    // everything: it empties the FIFO and drops the in-flight ROM return.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_reqValid <= 1'b0;
            r_reqPc    <= '0;
        end else if (flush) begin
            r_count    <= '0;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_reqValid <= 1'b0;
        end else begin
            r_reqValid <= w_issue;
            if (w_issue) begin
                r_reqPc <= pc_addr;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // FIFO storage needs no reset; entries are only visible through the
    // id_valid mask.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memPc[r_wrPtr]   <= r_reqPc;
            r_memInst[r_wrPtr] <= rom_data;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer
//
// Self-checking bench for fetch_buffer. A driver plays the role of the PC and
// the instruction ROM. Every fetch it issues is pushed into a scoreboard queue
// along with the instruction the ROM holds for that address. A separate
// monitor runs on the falling edge. It compares what decode sees against the
// oldest outstanding fetch, and it pops entries as decode consumes them.

module tb_fetch_buffer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          rom_en   = 1'b0;
    logic [AW-1:0] pc_addr  = '0;
    logic [DW-1:0] rom_data = '0;
    logic          flush    = 1'b0;
    logic          stall_id = 1'b0;
    logic          stall_pc;
    logic          id_valid;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_inst;

    fetch_buffer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rom_en  (rom_en),
        .pc_addr (pc_addr),
        .rom_data(rom_data),
        .flush   (flush),
        .stall_id(stall_id),
        .stall_pc(stall_pc),
        .id_valid(id_valid),
        .id_pc   (id_pc),
        .id_inst (id_inst)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
        int            issuedAt;
    } fetchItem_t;

    fetchItem_t    sbQ[$];
    int            checks   = 0;
    int            failures = 0;
    int            cycle    = 0;
    logic [AW-1:0] benchPc  = '0;
    logic [AW-1:0] prevPc   = '0;

    // Cycle index shared by driver and monitor, advanced at each rising edge.
    always @(posedge clk) cycle++;

    // ROM contents: a fixed scramble of the address, so every word is
    // distinctive and tied to its address.
    function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=0x%08h required=0x%08h",
                     name, cycle, actual, expected);
        end
    endtask

    // Drives one cycle just after the rising edge. The ROM returns the word
    // for last cycle's address. The PC only advances when a fetch is issued.
    // A fetch is issued only when fewer than DEPTH fetches are outstanding
    // and no flush is under way. A flush redirects the PC to the target.
    task automatic applyStimulus(input logic en, input logic sid, input logic fl,
                                 input logic [AW-1:0] target);
        logic issue;
        @(posedge clk);
        #1;
        rom_data = romWord(prevPc);
        pc_addr  = benchPc;
        rom_en   = en;
        stall_id = sid;
        flush    = fl;
        issue    = en && !rst && (sbQ.size() < DEPTH) && !fl;
        if (issue) begin
            sbQ.push_back('{pc: benchPc, inst: romWord(benchPc), issuedAt: cycle});
        end
        prevPc = benchPc;
        if (fl) begin
            benchPc = target;
        end else if (issue) begin
            benchPc = benchPc + 32'd4;
        end
    endtask

    // Drives a stalled cycle with queued work, then pulls reset in the middle
    // of that cycle. The outputs must clear before the next clock edge.
    task automatic midReset();
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_id_valid", 32'(id_valid), 32'd0);
        checkOutput("async_rst_id_pc", id_pc, 32'd0);
        checkOutput("async_rst_id_inst", id_inst, 32'd0);
        checkOutput("async_rst_stall_pc", 32'(stall_pc), 32'd0);
        sbQ.delete();
        benchPc = '0;
        prevPc  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    // Fetches issued before this cycle are outstanding and set stall_pc.
    // The oldest one is visible to decode once two cycles have passed since
    // its issue. A flush empties the scoreboard. Otherwise a visible head
    // that decode accepts is retired.
    always @(negedge clk) begin : monitorBlk
        int   older;
        logic expValid;
        if (rst) begin
            checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
            checkOutput("rst_id_pc", id_pc, 32'd0);
            checkOutput("rst_id_inst", id_inst, 32'd0);
            checkOutput("rst_stall_pc", 32'(stall_pc), 32'd0);
        end else begin
            older = 0;
            foreach (sbQ[i]) begin
                if (sbQ[i].issuedAt < cycle) older++;
            end
            checkOutput("stall_pc", 32'(stall_pc), 32'(older >= DEPTH));
            expValid = (sbQ.size() > 0) && (sbQ[0].issuedAt + 2 <= cycle);
            checkOutput("id_valid", 32'(id_valid), 32'(expValid));
            if (expValid) begin
                checkOutput("id_pc", id_pc, sbQ[0].pc);
                checkOutput("id_inst", id_inst, sbQ[0].inst);
            end else begin
                checkOutput("nop_id_pc", id_pc, 32'd0);
                checkOutput("nop_id_inst", id_inst, 32'd0);
            end
            checkOutput("no_overflow", 32'(dut.r_count <= DEPTH), 32'd1);
            if (flush) begin
                sbQ.delete();
            end else if (expValid && !stall_id) begin
                void'(sbQ.pop_front());
            end
        end
    end

    // Directed scenarios first, then a long randomized run.
    initial begin
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Straight-line streaming from address 0.
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, '0);

        // Decode stalls for four cycles, then releases.
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, '0);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, '0);

        // Fill up under a decode stall, then redirect to 0x100.
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, '0);

        // Decode stall and flush together: the flush wins.
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, '0);

        // Queue two entries, then drop rom_en and let them drain.
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, '0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, '0);

        // Asynchronous reset with entries queued, then a clean restart.
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, '0);
        midReset();
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, '0);

        // Randomized mix of fetch enables, decode stalls and redirects.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 9) < 8,
                          $urandom_range(0, 9) < 3,
                          $urandom_range(0, 19) == 0,
                          $urandom() & 32'hFFFF_FFFC);
        end

        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
